// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array read-out path.
package systolic_pkg;

    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN_SEND = 2'd1,
        DRAIN_DONE = 2'd2,
        DRAIN_HOLD = 2'd3
    } drain_state_e;

    function automatic int idx_w(input int size);
        int w;
        w = $clog2(size * size);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/systolic_quant.sv
// Rescales a signed accumulator by an arithmetic right shift and saturates it
// to a signed OUT_W-bit word.
module systolic_quant #(
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 8
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [OUT_W-1:0] q
);

    localparam logic [ACC_W-1:0] ONE = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] MAX_S = signed'((ONE << (OUT_W - 1)) - ONE);
    localparam logic signed [ACC_W-1:0] MIN_S = signed'(~((ONE << (OUT_W - 1)) - ONE));

    logic signed [ACC_W-1:0] shifted_s;

    // Shift toward -inf, then clamp into the output range.
    always_comb begin
        shifted_s = acc >>> FRAC_SHIFT;
        if (shifted_s > MAX_S) begin
            q = MAX_S[OUT_W-1:0];
        end else if (shifted_s < MIN_S) begin
            q = MIN_S[OUT_W-1:0];
        end else begin
            q = shifted_s[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/systolic_drain.sv
// Snapshots all PE accumulators when the array reports completion and streams
// them out row-major, quantised, over a val/rdy interface; pulses clr when done.
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int SIZE       = 4,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       drain_req,
    input  logic [SIZE*SIZE*ACC_W-1:0] acc_data,
    output logic [OUT_W-1:0]           send_msg,
    output logic                       send_val,
    input  logic                       send_rdy,
    output logic                       send_last,
    output logic                       busy,
    output logic                       done,
    output logic                       clr
);

    localparam int NUM   = SIZE * SIZE;
    localparam int IDX_W = idx_w(SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

    drain_state_e      state_r, state_s;
    logic [IDX_W-1:0]  idx_r, idx_s;
    logic [ACC_W-1:0]  snap_r [NUM];
    logic              load_s;
    logic              xfer_s;
    logic [ACC_W-1:0]  quant_in_s;
    logic [OUT_W-1:0]  quant_out_s;
    logic [OUT_W-1:0]  send_msg_r, send_msg_s;
    logic              send_val_r, send_val_s;
    logic              send_last_r, send_last_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;

    // Outputs are precomputed for the next state so every port is a flop:
    // the word quantised here is the one presented after the coming edge.
    systolic_quant #(
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_quant (
        .acc (quant_in_s),
        .q   (quant_out_s)
    );

    // Next-state, next-index and next-output decode.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        load_s  = 1'b0;
        xfer_s  = send_val_r & send_rdy;
        case (state_r)
            DRAIN_IDLE: begin
                if (drain_req) begin
                    state_s = DRAIN_SEND;
                    idx_s   = {IDX_W{1'b0}};
                    load_s  = 1'b1;
                end else begin
                    state_s = DRAIN_IDLE;
                end
            end
            DRAIN_SEND: begin
                if (xfer_s && send_last_r) begin
                    state_s = DRAIN_DONE;
                end else if (xfer_s) begin
                    idx_s = idx_r + IDX_W'(1);
                end else begin
                    state_s = DRAIN_SEND;
                end
            end
            DRAIN_DONE: begin
                state_s = DRAIN_HOLD;
            end
            DRAIN_HOLD: begin
                // Wait for drain_req to drop so one result set drains only once.
                if (!drain_req) begin
                    state_s = DRAIN_IDLE;
                end else begin
                    state_s = DRAIN_HOLD;
                end
            end
            default: begin
                state_s = DRAIN_IDLE;
                idx_s   = {IDX_W{1'b0}};
            end
        endcase

        if (load_s) begin
            quant_in_s = acc_data[ACC_W-1:0];
        end else begin
            quant_in_s = snap_r[idx_s];
        end

        send_val_s  = (state_s == DRAIN_SEND);
        send_last_s = (state_s == DRAIN_SEND) && (idx_s == LAST_IDX);
        busy_s      = (state_s != DRAIN_IDLE);
        done_s      = (state_s == DRAIN_DONE);
        if (state_s == DRAIN_SEND) begin
            send_msg_s = quant_out_s;
        end else begin
            send_msg_s = {OUT_W{1'b0}};
        end
    end

    // State, index, snapshot and registered output flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= DRAIN_IDLE;
            idx_r       <= {IDX_W{1'b0}};
            send_msg_r  <= {OUT_W{1'b0}};
            send_val_r  <= 1'b0;
            send_last_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            for (int i = 0; i < NUM; i++) begin
                snap_r[i] <= {ACC_W{1'b0}};
            end
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            send_msg_r  <= send_msg_s;
            send_val_r  <= send_val_s;
            send_last_r <= send_last_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            if (load_s) begin
                for (int i = 0; i < NUM; i++) begin
                    snap_r[i] <= acc_data[i*ACC_W +: ACC_W];
                end
            end
        end
    end

    assign send_msg  = send_msg_r;
    assign send_val  = send_val_r;
    assign send_last = send_last_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign clr       = done_r;

endmodule
